pwm_servo_decoder: RTL and testbench
====================================

Name: pwm_servo_decoder

Overview:
- Receive side of the MG995 servo PWM interface: measures an incoming servo pulse train and decodes it back to the 2-bit angle select code the servo PWM generator consumes (0 = none, 1 = 0°, 2 = 90°, 3 = 180°).
- Used for loopback self-test of the generator and for accepting commands from an external RC receiver.
- Synchronous single-clock design, 50 MHz nominal on the Spartan 6 target.

Parameters:
- ANGLE_0_CYCLES, 25000, nominal high time for 0° (0.5 ms).
- ANGLE_90_CYCLES, 75000, nominal high time for 90° (1.5 ms).
- ANGLE_180_CYCLES, 125000, nominal high time for 180° (2.5 ms).
- WIDTH_TOL_CYCLES, 2500, ± tolerance on high time for classification (50 µs).
- PERIOD_CYCLES, 1000000, nominal frame period (20 ms).
- PERIOD_TOL_CYCLES, 50000, ± tolerance on frame period (1 ms).
- TIMEOUT_CYCLES, 1250000, cycles without any edge before declaring loss of signal (25 ms).
- WIDTH_W, 21, width of all counters and of Width_o.
- STABLE_FRAMES, 3, consecutive matching frames required; used only with the optional feature.

Ports:
- Clk_i  input  1  system clock.
- Reset_i  input  1  asynchronous, active-low reset.
- Pwm_i  input  1  asynchronous servo PWM line.
- Sel_angle_o  output  2  decoded angle code.
- Width_o  output  WIDTH_W  high time of last accepted frame, in clock cycles.
- Frame_valid_o  output  1  one-cycle pulse: frame accepted.
- Frame_err_o  output  1  one-cycle pulse: frame period out of range.
- Timeout_o  output  1  sticky loss-of-signal flag.

Behaviour:
- Reset (asynchronous, Reset_i low):
  - All outputs, counters and synchronizer flops go to 0 immediately; state goes to S_IDLE.
  - Reset asserted mid-frame discards the frame.
- Input synchronizer and edge detect:
  - Pwm_i passes through two flops (s1, s2) plus a delay flop s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - Pin-to-edge latency is 3 cycles.
- Counters:
  - hi_cnt counts cycles with s2 = 1 inside the frame.
  - per_cnt counts cycles since the last rise.
  - Both are loaded with 1 on the rise cycle and saturate at all ones.
- State S_IDLE:
  - Counters held at 0.
  - rise -> S_HIGH; no frame is evaluated on this first edge.
- State S_HIGH:
  - hi_cnt and per_cnt increment each cycle.
  - fall -> S_LOW; hi_cnt freezes.
- State S_LOW:
  - per_cnt increments each cycle.
  - rise -> frame evaluation, then S_HIGH with counters reloaded to 1 on the same cycle.
- Frame evaluation (in the cycle after the rise, registered):
  - Period check: if |per_cnt − PERIOD_CYCLES| ≤ PERIOD_TOL_CYCLES, the frame is accepted.
  - On acceptance:
    - Frame_valid_o pulses for 1 cycle and Width_o <= hi_cnt.
    - Timeout_o <= 0.
    - Sel_angle_o <= 1, 2 or 3 if hi_cnt lies within ANGLE_x ± WIDTH_TOL_CYCLES (inclusive bounds), else 0.
  - Out-of-range period: Frame_err_o pulses for 1 cycle; Sel_angle_o, Width_o and Timeout_o are unchanged.
- Output latency: Sel_angle_o, Width_o and Frame_valid_o update 4 cycles after the pin rising edge that ends the frame.
- Timeout:
  - Applies in S_HIGH or S_LOW. When per_cnt reaches TIMEOUT_CYCLES with no rise (line stuck high or stuck low):
    - state goes to S_IDLE;
    - Sel_angle_o <= 0;
    - Timeout_o <= 1;
    - no Frame_err_o pulse.
  - A rise on the same cycle as the timeout condition takes priority: the frame is evaluated and there is no timeout.
- Arithmetic:
  - All comparisons are unsigned at WIDTH_W bits.
  - Parameter bounds are computed as constants; WIDTH_W must cover TIMEOUT_CYCLES.
- Frame_valid_o and Frame_err_o are never high in the same cycle.

Optional Feature:
- Macro: PWM_SERVO_DECODER_STABLE_EN.
- Defined:
  - Sel_angle_o changes only after STABLE_FRAMES consecutive accepted frames have the same classification.
  - A frame with a different classification restarts the run count at 1.
  - Frame_err_o and timeout both clear the run count; timeout still forces Sel_angle_o to 0.
  - Width_o and Frame_valid_o still update on every accepted frame.
- Undefined: Sel_angle_o updates on every accepted frame, as specified under Behaviour.

Test Plan:
- Reset: 1 ms of Pwm_i toggling, then Reset_i low mid-frame -> all outputs 0 at once; state S_IDLE; after release, first rise produces no Frame_valid_o.
- Angle decode: 5 frames each of period 1000000 and high 25000, then 75000, then 125000 -> Sel_angle_o = 1, 2, 3 respectively; Width_o exactly equals the driven high time; Frame_valid_o pulses once per frame, 4 cycles after the rise.
- Tolerance bounds: high time 77500 -> Sel_angle_o = 2; high time 77501 -> Sel_angle_o = 0 with Frame_valid_o still pulsing.
- Period bounds: period 1050000 -> accepted; period 1050001 -> Frame_err_o pulse, Sel_angle_o and Width_o hold their previous values.
- Stuck line: line held high after a valid 90° frame -> after 1250000 cycles from the last rise, Timeout_o = 1 and Sel_angle_o = 0; the next valid frame clears Timeout_o.
- With PWM_SERVO_DECODER_STABLE_EN: sequence 90°, 90°, 180°, 180°, 180° frames from Sel_angle_o = 0 -> Sel_angle_o stays 0 until the 5th frame evaluates, then becomes 3.

Source files
------------

// File: rtl/pwm_servo_decoder.sv
// pwm_servo_decoder
//   Receive side of the MG995 servo PWM interface. Measures the high time and
//   the period of an incoming servo pulse train and decodes the high time back
//   to the 2-bit angle select code (0 = none, 1 = 0 deg, 2 = 90 deg, 3 = 180 deg).
//
//   Ports:
//     Clk_i          system clock
//     Reset_i        asynchronous, active-low reset
//     Pwm_i          asynchronous servo PWM line
//     Sel_angle_o    decoded angle code
//     Width_o        high time of the last accepted frame, in clock cycles
//     Frame_valid_o  one-cycle pulse: frame accepted
//     Frame_err_o    one-cycle pulse: frame period out of range
//     Timeout_o      sticky loss-of-signal flag
//
//   Optional feature (macro PWM_SERVO_DECODER_STABLE_EN): Sel_angle_o only
//   changes after STABLE_FRAMES consecutive accepted frames classify the same.
module pwm_servo_decoder #(
  parameter int unsigned ANGLE_0_CYCLES    = 25000,
  parameter int unsigned ANGLE_90_CYCLES   = 75000,
  parameter int unsigned ANGLE_180_CYCLES  = 125000,
  parameter int unsigned WIDTH_TOL_CYCLES  = 2500,
  parameter int unsigned PERIOD_CYCLES     = 1000000,
  parameter int unsigned PERIOD_TOL_CYCLES = 50000,
  parameter int unsigned TIMEOUT_CYCLES    = 1250000,
  parameter int unsigned WIDTH_W           = 21,
  parameter int unsigned STABLE_FRAMES     = 3
) (
  input  logic               Clk_i,
  input  logic               Reset_i,
  input  logic               Pwm_i,
  output logic [1:0]         Sel_angle_o,
  output logic [WIDTH_W-1:0] Width_o,
  output logic               Frame_valid_o,
  output logic               Frame_err_o,
  output logic               Timeout_o
);

  typedef logic [WIDTH_W-1:0] cnt_t;

  localparam cnt_t PER_MIN  = cnt_t'(PERIOD_CYCLES - PERIOD_TOL_CYCLES);
  localparam cnt_t PER_MAX  = cnt_t'(PERIOD_CYCLES + PERIOD_TOL_CYCLES);
  localparam cnt_t A0_MIN   = cnt_t'(ANGLE_0_CYCLES - WIDTH_TOL_CYCLES);
  localparam cnt_t A0_MAX   = cnt_t'(ANGLE_0_CYCLES + WIDTH_TOL_CYCLES);
  localparam cnt_t A90_MIN  = cnt_t'(ANGLE_90_CYCLES - WIDTH_TOL_CYCLES);
  localparam cnt_t A90_MAX  = cnt_t'(ANGLE_90_CYCLES + WIDTH_TOL_CYCLES);
  localparam cnt_t A180_MIN = cnt_t'(ANGLE_180_CYCLES - WIDTH_TOL_CYCLES);
  localparam cnt_t A180_MAX = cnt_t'(ANGLE_180_CYCLES + WIDTH_TOL_CYCLES);
  localparam cnt_t TMO_LIM  = cnt_t'(TIMEOUT_CYCLES);

  // Counters must be able to reach the timeout limit without wrapping.
  if (64'(TIMEOUT_CYCLES) >= (64'd1 << WIDTH_W) || STABLE_FRAMES == 0) begin : g_param_check
    $error("pwm_servo_decoder: WIDTH_W too small for TIMEOUT_CYCLES or STABLE_FRAMES is 0");
  end

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

  state_t     state;
  logic       s1, s2, s3;
  logic       rise, fall;
  cnt_t       hi_cnt, per_cnt;
  logic       per_ok, tmo_hit;
  logic [1:0] cls;

  // Evaluation snapshot taken on the rise cycle, applied one cycle later.
  logic       ev_pend, ev_ok;
  logic [1:0] ev_sel;
  cnt_t       ev_hi;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

  always_comb begin
    rise    = s2 & ~s3;
    fall    = ~s2 & s3;
    per_ok  = (per_cnt >= PER_MIN) && (per_cnt <= PER_MAX);
    tmo_hit = (per_cnt >= TMO_LIM);
    cls     = 2'd0;
    if (hi_cnt >= A0_MIN && hi_cnt <= A0_MAX)          cls = 2'd1;
    else if (hi_cnt >= A90_MIN && hi_cnt <= A90_MAX)   cls = 2'd2;
    else if (hi_cnt >= A180_MIN && hi_cnt <= A180_MAX) cls = 2'd3;
  end

`ifdef PWM_SERVO_DECODER_STABLE_EN
  localparam cnt_t STABLE_N = cnt_t'(STABLE_FRAMES);
  cnt_t       run_cnt, run_next;
  logic [1:0] run_sel;

  always_comb begin
    run_next = cnt_t'(1);
    if (run_cnt != '0 && ev_sel == run_sel) run_next = sat_inc(run_cnt);
  end
`endif

  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      s1            <= 1'b0;
      s2            <= 1'b0;
      s3            <= 1'b0;
      state         <= S_IDLE;
      hi_cnt        <= '0;
      per_cnt       <= '0;
      ev_pend       <= 1'b0;
      ev_ok         <= 1'b0;
      ev_sel        <= '0;
      ev_hi         <= '0;
      Sel_angle_o   <= '0;
      Width_o       <= '0;
      Frame_valid_o <= 1'b0;
      Frame_err_o   <= 1'b0;
      Timeout_o     <= 1'b0;
`ifdef PWM_SERVO_DECODER_STABLE_EN
      run_cnt       <= '0;
      run_sel       <= '0;
`endif
    end else begin
      s1            <= Pwm_i;
      s2            <= s1;
      s3            <= s2;
      Frame_valid_o <= 1'b0;
      Frame_err_o   <= 1'b0;
      ev_pend       <= 1'b0;

      if (ev_pend) begin
        if (ev_ok) begin
          Frame_valid_o <= 1'b1;
          Width_o       <= ev_hi;
          Timeout_o     <= 1'b0;
`ifdef PWM_SERVO_DECODER_STABLE_EN
          run_cnt <= run_next;
          run_sel <= ev_sel;
          if (run_next >= STABLE_N) Sel_angle_o <= ev_sel;
`else
          Sel_angle_o <= ev_sel;
`endif
        end else begin
          Frame_err_o <= 1'b1;
`ifdef PWM_SERVO_DECODER_STABLE_EN
          run_cnt <= '0;
`endif
        end
      end

      case (state)
        S_IDLE: begin
          hi_cnt  <= '0;
          per_cnt <= '0;
          if (rise) begin
            state   <= S_HIGH;
            hi_cnt  <= cnt_t'(1);
            per_cnt <= cnt_t'(1);
          end
        end
        default: begin
          // A rise coinciding with the timeout limit closes the frame normally.
          if (rise) begin
            ev_pend <= 1'b1;
            ev_ok   <= per_ok;
            ev_sel  <= cls;
            ev_hi   <= hi_cnt;
            state   <= S_HIGH;
            hi_cnt  <= cnt_t'(1);
            per_cnt <= cnt_t'(1);
          end else if (tmo_hit) begin
            state       <= S_IDLE;
            hi_cnt      <= '0;
            per_cnt     <= '0;
            Sel_angle_o <= '0;
            Timeout_o   <= 1'b1;
`ifdef PWM_SERVO_DECODER_STABLE_EN
            run_cnt     <= '0;
`endif
          end else begin
            per_cnt <= sat_inc(per_cnt);
            if (state == S_HIGH) begin
              if (fall) state  <= S_LOW;
              else      hi_cnt <= sat_inc(hi_cnt);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_servo_decoder.sv
// Testbench for pwm_servo_decoder, using scaled-down timing parameters.
// The reference model works on pin edge times: a frame closed by a rise at
// pin-sample cycle k reports at cycle k+3; a rise at cycle k with no further
// rise within TMO cycles times out at cycle k+2+TMO.
module tb_pwm_servo_decoder;
  localparam int unsigned A0 = 25, A90 = 75, A180 = 125, WT = 5;
  localparam int unsigned PER = 400, PT = 20, TMO = 500, WW = 10;

  logic          clk = 1'b0, rst_n = 1'b0, pin = 1'b0;
  logic [1:0]    sel;
  logic [WW-1:0] width;
  logic          fv, fe, to;

  pwm_servo_decoder #(
    .ANGLE_0_CYCLES(A0), .ANGLE_90_CYCLES(A90), .ANGLE_180_CYCLES(A180),
    .WIDTH_TOL_CYCLES(WT), .PERIOD_CYCLES(PER), .PERIOD_TOL_CYCLES(PT),
    .TIMEOUT_CYCLES(TMO), .WIDTH_W(WW), .STABLE_FRAMES(3)
  ) dut (
    .Clk_i(clk), .Reset_i(rst_n), .Pwm_i(pin), .Sel_angle_o(sel), .Width_o(width),
    .Frame_valid_o(fv), .Frame_err_o(fe), .Timeout_o(to)
  );

  always #5 clk = ~clk;

  int unsigned ncyc = 0;
  always @(posedge clk) ncyc <= ncyc + 1;

  int unsigned checks = 0, errors = 0;
  int unsigned vcount = 0, ecount = 0, used = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s at cycle %0d: got %0d expected %0d", name, ncyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          have_prev = 0;
  int unsigned prev_rise = 0, last_fall = 0;
  int unsigned tmo_q[$];
  bit          ev_pend = 0, ev_ok = 0;
  int unsigned ev_at = 0, ev_w = 0;
  int unsigned ev_sel = 0;
  int unsigned e_sel = 0, e_w = 0, e_tmo = 0;
  int unsigned run_n = 0, run_sel = 0;

  function automatic int unsigned classify(input int unsigned h);
    int d0, d90, d180;
    d0 = int'(h) - int'(A0); d90 = int'(h) - int'(A90); d180 = int'(h) - int'(A180);
    if (d0 >= -int'(WT) && d0 <= int'(WT)) return 1;
    if (d90 >= -int'(WT) && d90 <= int'(WT)) return 2;
    if (d180 >= -int'(WT) && d180 <= int'(WT)) return 3;
    return 0;
  endfunction

  task automatic model_rise(input int unsigned k);
    int p;
    if (have_prev && (k - prev_rise) <= TMO) begin
      if (tmo_q.size() > 0) void'(tmo_q.pop_back());
      p       = int'(k - prev_rise) - int'(PER);
      ev_pend = 1;
      ev_at   = k + 3;
      ev_ok   = (p >= -int'(PT)) && (p <= int'(PT));
      ev_w    = last_fall - prev_rise;
      ev_sel  = classify(ev_w);
    end
    have_prev = 1;
    prev_rise = k;
    tmo_q.push_back(k + 2 + TMO);
  endtask

  task automatic model_reset();
    have_prev = 0; tmo_q.delete(); ev_pend = 0;
    e_sel = 0; e_w = 0; e_tmo = 0; run_n = 0; run_sel = 0;
  endtask

  always @(negedge clk) begin
    int unsigned n, xv, xe;
    if (rst_n) begin
      n = ncyc; xv = 0; xe = 0;
      while (tmo_q.size() > 0 && tmo_q[0] <= n) begin
        void'(tmo_q.pop_front());
        e_sel = 0; e_tmo = 1; run_n = 0;
      end
      if (ev_pend && ev_at == n) begin
        ev_pend = 0;
        if (ev_ok) begin
          xv = 1; e_w = ev_w; e_tmo = 0;
`ifdef PWM_SERVO_DECODER_STABLE_EN
          if (run_n > 0 && ev_sel == run_sel) run_n++;
          else begin run_n = 1; run_sel = ev_sel; end
          if (run_n >= 3) e_sel = ev_sel;
`else
          e_sel = ev_sel;
`endif
        end else begin
          xe = 1; run_n = 0;
        end
      end
      check("sel",   32'(sel),   e_sel);
      check("width", 32'(width), e_w);
      check("valid", 32'(fv),    xv);
      check("err",   32'(fe),    xe);
      check("tmo",   32'(to),    e_tmo);
      vcount += 32'(fv);
      ecount += 32'(fe);
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_pin(input logic v);
    @(negedge clk); #1;
    if (v && !pin) model_rise(ncyc + 1);
    if (!v && pin) last_fall = ncyc + 1;
    pin = v;
  endtask

  // Continues a frame whose rise was just driven; ends with the next rise.
  task automatic frame(input int unsigned h, input int unsigned p);
    repeat (h - 1 - used) @(negedge clk);
    used = 0;
    set_pin(1'b0);
    repeat (p - h - 1) @(negedge clk);
    set_pin(1'b1);
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
    used += 6;
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned vb, eb, h, p, r;
    int unsigned bases [4];
    bases = '{A0, A90, A180, 60};

    repeat (3) @(negedge clk);
    check("rst_sel", 32'(sel), 0);   check("rst_width", 32'(width), 0);
    check("rst_valid", 32'(fv), 0);  check("rst_err", 32'(fe), 0);
    check("rst_tmo", 32'(to), 0);
    @(negedge clk); #2 rst_n = 1'b1;

    // Toggle, then reset in the middle of a high phase.
    set_pin(1'b1);
    frame(50, PER); frame(50, PER);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0; model_reset();
    #1;
    check("midrst_sel", 32'(sel), 0);   check("midrst_width", 32'(width), 0);
    check("midrst_tmo", 32'(to), 0);    check("midrst_valid", 32'(fv), 0);
    set_pin(1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Angle decode; the first rise after reset only opens a frame.
    vb = vcount; used = 0;
    set_pin(1'b1);
    frame(A0, PER); settle();
    check("first_rise_valid_cnt", vcount - vb, 1);
    repeat (4) frame(A0, PER);
    settle();
    check("a0_sel", 32'(sel), 1); check("a0_width", 32'(width), A0);
    check("a0_valid_cnt", vcount - vb, 5);
    repeat (5) frame(A90, PER);
    settle();
    check("a90_sel", 32'(sel), 2); check("a90_width", 32'(width), A90);
    repeat (5) frame(A180, PER);
    settle();
    check("a180_sel", 32'(sel), 3); check("a180_width", 32'(width), A180);

    // Width tolerance bounds.
    vb = vcount;
    frame(A90 + WT, PER); settle();
    check("tol_hi_in_width", 32'(width), A90 + WT);
    frame(A90 + WT + 1, PER); settle();
    check("tol_hi_out_width", 32'(width), A90 + WT + 1);
    check("tol_valid_cnt", vcount - vb, 2);
`ifndef PWM_SERVO_DECODER_STABLE_EN
    check("tol_hi_out_sel", 32'(sel), 0);
    frame(A90 + WT, PER); settle();
    check("tol_hi_in_sel", 32'(sel), 2);
    frame(A90 - WT - 1, PER); settle();
    check("tol_lo_out_sel", 32'(sel), 0);
    frame(A90 - WT, PER); settle();
    check("tol_lo_in_sel", 32'(sel), 2);
`endif

    // Period bounds.
    frame(A90, PER); frame(A90, PER + PT); settle();
    check("per_max_width", 32'(width), A90);
    eb = ecount;
    frame(A180, PER + PT + 1); settle();
    check("per_over_err_cnt", ecount - eb, 1);
    check("per_over_width_hold", 32'(width), A90);
`ifndef PWM_SERVO_DECODER_STABLE_EN
    check("per_over_sel_hold", 32'(sel), 2);
`endif
    frame(A0, PER - PT); settle();
    check("per_min_width", 32'(width), A0);
    frame(A90, PER - PT - 1); settle();
    check("per_under_err_cnt", ecount - eb, 2);

    // Stuck-high line after a valid 90 deg frame.
    frame(A90, PER); frame(A90, PER);
    repeat (TMO + 10) @(negedge clk);
    check("stuck_tmo", 32'(to), 1); check("stuck_sel", 32'(sel), 0);
    set_pin(1'b0);
    repeat (20) @(negedge clk);
    set_pin(1'b1); used = 0;
    frame(A90, PER); settle();
    check("recover_tmo", 32'(to), 0);
`ifndef PWM_SERVO_DECODER_STABLE_EN
    check("recover_sel", 32'(sel), 2);
`else
    // Leave the line idle long enough to time out, then run 90,90,180,180,180.
    set_pin(1'b0);
    repeat (TMO + 10) @(negedge clk);
    set_pin(1'b1); used = 0;
    frame(A90, PER); frame(A90, PER); frame(A180, PER); frame(A180, PER); settle();
    check("stable_sel_hold", 32'(sel), 0);
    frame(A180, PER); settle();
    check("stable_sel_set", 32'(sel), 3);
`endif

    // Randomized frames around the decision boundaries.
    for (int i = 0; i < 25; i++) begin
      h = bases[$urandom_range(0, 3)] + $urandom_range(0, 16) - 8;
      r = $urandom_range(0, 9);
      if (r < 7)      p = $urandom_range(PER - PT - 5, PER + PT + 5);
      else if (r < 9) p = $urandom_range(PER + PT + 10, PER + 80);
      else            p = $urandom_range(TMO + 2, TMO + 60);
      frame(h, p);
    end
    settle();
    set_pin(1'b0);
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
